// File: rtl/fpu_exception_pipe_if.sv
// fpu_exception_pipe_if: operand/result handshake bundle for the FPU special-case detector.
// master drives operations and accepts results; slave is the detector.
interface fpu_exception_pipe_if #(
   parameter int EXP_W = 4,
   parameter int MAN_W = 3
);
   localparam int W = 1 + EXP_W + MAN_W;

   logic [1:0]   FP_OPERATION;
   logic [W-1:0] OP_A;
   logic [W-1:0] OP_B;
   logic         IN_VALID;
   logic         IN_READY;
   logic         OUT_VALID;
   logic         OUT_READY;
   logic         OUT_IS_EXCEPTION;
   logic [W-1:0] EXC_RESULT;
   logic [2:0]   EXC_FLAGS;
   logic [2:0]   STICKY_FLAGS;
   logic         STICKY_CLR;

   modport master (
      output FP_OPERATION, OP_A, OP_B, IN_VALID, OUT_READY, STICKY_CLR,
      input  IN_READY, OUT_VALID, OUT_IS_EXCEPTION, EXC_RESULT,
      input  EXC_FLAGS, STICKY_FLAGS
   );

   modport slave (
      input  FP_OPERATION, OP_A, OP_B, IN_VALID, OUT_READY, STICKY_CLR,
      output IN_READY, OUT_VALID, OUT_IS_EXCEPTION, EXC_RESULT,
      output EXC_FLAGS, STICKY_FLAGS
   );
endinterface

// File: rtl/fpu_exception_pipe.sv
// fpu_exception_pipe: 2-stage special-operand detector for add/sub/mul/div.
// Sticky flag accumulation is built only when FPU_EXC_STICKY_EN is defined.
module fpu_exception_pipe #(
   parameter int EXP_W = 4,
   parameter int MAN_W = 3
) (
   input logic                 CLK,
   input logic                 RST,
   fpu_exception_pipe_if.slave bus
);
   localparam int W = 1 + EXP_W + MAN_W;

   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   localparam logic [EXP_W-1:0] EXP_ONES = '1;
   localparam logic [MAN_W-1:0] MAN_Q = MAN_W'(1) << (MAN_W - 1);
   localparam logic [W-1:0] QNAN = {1'b0, EXP_ONES, MAN_Q};

   localparam logic [2:0] F_INV = 3'b100;
   localparam logic [2:0] F_DBZ = 3'b010;
   localparam logic [2:0] F_NAN = 3'b001;

   typedef enum logic [1:0] {
      C_ZERO,
      C_FIN,
      C_INF,
      C_NAN
   } cls_t;

   function automatic cls_t classify(input logic [W-1:0] v);
      logic e_ones;
      logic e_zero;
      logic m_zero;
      e_ones = &v[W-2 -: EXP_W];
      e_zero = ~|v[W-2 -: EXP_W];
      m_zero = ~|v[MAN_W-1:0];
      if (e_ones) return m_zero ? C_INF : C_NAN;
      if (e_zero && m_zero) return C_ZERO;
      return C_FIN;
   endfunction

   function automatic logic [W-1:0] inf_of(input logic s);
      return {s, EXP_ONES, {MAN_W{1'b0}}};
   endfunction

   function automatic logic [W-1:0] zero_of(input logic s);
      return {s, {(W-1){1'b0}}};
   endfunction

   logic       s1_valid;
   logic [1:0] s1_op;
   logic       s1_sa;
   logic       s1_sb;
   cls_t       s1_ca;
   cls_t       s1_cb;

   logic         s2_valid;
   logic         s2_exc;
   logic [W-1:0] s2_res;
   logic [2:0]   s2_flg;

   logic s2_adv;
   logic s1_adv;

   assign s2_adv = !s2_valid || bus.OUT_READY;
   assign s1_adv = !s1_valid || s2_adv;

   // S1: classify operands; sub folds into add by flipping B's sign
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         s1_valid <= 1'b0;
         s1_op    <= 2'b00;
         s1_sa    <= 1'b0;
         s1_sb    <= 1'b0;
         s1_ca    <= C_ZERO;
         s1_cb    <= C_ZERO;
      end else if (s1_adv) begin
         s1_valid <= bus.IN_VALID;
         s1_op    <= bus.FP_OPERATION;
         s1_sa    <= bus.OP_A[W-1];
         s1_sb    <= bus.OP_B[W-1] ^ (bus.FP_OPERATION == OP_SUB);
         s1_ca    <= classify(bus.OP_A);
         s1_cb    <= classify(bus.OP_B);
      end
   end

   logic         nx_exc;
   logic [W-1:0] nx_res;
   logic [2:0]   nx_flg;
   logic         any_nan;
   logic         any_inf;
   logic         sx;

   always_comb begin
      nx_exc  = 1'b0;
      nx_res  = '0;
      nx_flg  = 3'b000;
      any_nan = (s1_ca == C_NAN) || (s1_cb == C_NAN);
      any_inf = (s1_ca == C_INF) || (s1_cb == C_INF);
      sx      = s1_sa ^ s1_sb;
      if (any_nan) begin
         nx_exc = 1'b1;
         nx_res = QNAN;
         nx_flg = F_NAN;
      end else begin
         case (s1_op)
            OP_MUL: begin
               if ((s1_ca == C_ZERO && s1_cb == C_INF) ||
                   (s1_ca == C_INF && s1_cb == C_ZERO)) begin
                  nx_exc = 1'b1;
                  nx_res = QNAN;
                  nx_flg = F_INV;
               end else if (any_inf) begin
                  nx_exc = 1'b1;
                  nx_res = inf_of(sx);
               end
            end
            OP_DIV: begin
               if ((s1_ca == C_ZERO && s1_cb == C_ZERO) ||
                   (s1_ca == C_INF && s1_cb == C_INF)) begin
                  nx_exc = 1'b1;
                  nx_res = QNAN;
                  nx_flg = F_INV;
               end else if (s1_ca == C_FIN && s1_cb == C_ZERO) begin
                  nx_exc = 1'b1;
                  nx_res = inf_of(sx);
                  nx_flg = F_DBZ;
               end else if (s1_ca == C_INF) begin
                  nx_exc = 1'b1;
                  nx_res = inf_of(sx);
               end else if (s1_cb == C_INF) begin
                  nx_exc = 1'b1;
                  nx_res = zero_of(sx);
               end
            end
            default: begin
               if (s1_ca == C_INF && s1_cb == C_INF && s1_sa != s1_sb) begin
                  nx_exc = 1'b1;
                  nx_res = QNAN;
                  nx_flg = F_INV;
               end else if (s1_ca == C_INF) begin
                  nx_exc = 1'b1;
                  nx_res = inf_of(s1_sa);
               end else if (s1_cb == C_INF) begin
                  nx_exc = 1'b1;
                  nx_res = inf_of(s1_sb);
               end
            end
         endcase
      end
   end

   // S2: bubbles register as all-zero so outputs are clean when idle
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         s2_valid <= 1'b0;
         s2_exc   <= 1'b0;
         s2_res   <= '0;
         s2_flg   <= 3'b000;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         s2_exc   <= s1_valid & nx_exc;
         s2_res   <= s1_valid ? nx_res : '0;
         s2_flg   <= s1_valid ? nx_flg : 3'b000;
      end
   end

   assign bus.IN_READY         = s1_adv;
   assign bus.OUT_VALID        = s2_valid;
   assign bus.OUT_IS_EXCEPTION = s2_exc;
   assign bus.EXC_RESULT       = s2_res;
   assign bus.EXC_FLAGS        = s2_flg;

`ifdef FPU_EXC_STICKY_EN
   logic [2:0] sticky;
   logic       out_hs;

   assign out_hs = s2_valid && bus.OUT_READY;

   // clear wins, but the flags of a coincident handshake survive it
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sticky <= 3'b000;
      end else if (bus.STICKY_CLR) begin
         sticky <= out_hs ? s2_flg : 3'b000;
      end else if (out_hs) begin
         sticky <= sticky | s2_flg;
      end
   end

   assign bus.STICKY_FLAGS = sticky;
`else
   logic unused_sticky_clr;
   assign unused_sticky_clr = bus.STICKY_CLR;
   assign bus.STICKY_FLAGS  = 3'b000;
`endif
endmodule

// File: tb/tb_fpu_exception_pipe.sv
// tb_fpu_exception_pipe: directed vectors with a queue scoreboard and output monitor.
// Covers latency, stall hold, backpressure, reset flush and (if built) sticky flags.
module tb_fpu_exception_pipe;
   localparam int EXP_W = 4;
   localparam int MAN_W = 3;
   localparam int W = 8;

   localparam logic [1:0] ADD = 2'b00;
   localparam logic [1:0] SUB = 2'b01;
   localparam logic [1:0] MUL = 2'b10;
   localparam logic [1:0] DIV = 2'b11;

   logic CLK = 1'b0;
   logic RST = 1'b1;

   always #5 CLK = ~CLK;

   fpu_exception_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

   fpu_exception_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   typedef logic [11:0] rsp_t;

   typedef struct packed {
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      rsp_t         r;
   } vec_t;

   rsp_t sb[$];
   vec_t vt[21];
   int   n_vec = 0;
   int   n_err = 0;

   function automatic rsp_t R(input logic e, input logic [7:0] res, input logic [2:0] f);
      return {e, res, f};
   endfunction

   function automatic vec_t V(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                              input rsp_t r);
      vec_t v;
      v.op = op;
      v.a  = a;
      v.b  = b;
      v.r  = r;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   rsp_t cur;
   rsp_t held;
   rsp_t got;
   rsp_t want;
   logic stalled = 1'b0;

   assign cur = {bus.OUT_IS_EXCEPTION, bus.EXC_RESULT, bus.EXC_FLAGS};

   // scoreboard monitor: pops one expectation per output handshake
   always @(negedge CLK) begin
      if (!RST && bus.OUT_VALID && bus.OUT_READY) begin
         if (sb.size() == 0) begin
            check("unexpected_out", 32'd1, 32'd0);
         end else begin
            want = sb.pop_front();
            got  = cur;
            check("beat", 32'(got), 32'(want));
         end
      end
   end

   always @(negedge CLK) begin
      if (!RST && stalled)
         check("stall_hold", {19'd0, bus.OUT_VALID, cur}, {19'd0, 1'b1, held});
      stalled <= !RST && bus.OUT_VALID && !bus.OUT_READY;
      held    <= cur;
   end

   task automatic send(input vec_t v, input logic expect_it);
      int n = 0;
      bus.FP_OPERATION = v.op;
      bus.OP_A         = v.a;
      bus.OP_B         = v.b;
      bus.IN_VALID     = 1'b1;
      @(negedge CLK);
      while (!bus.IN_READY && n < 100) begin
         n++;
         @(negedge CLK);
      end
      if (!bus.IN_READY) check("in_ready_timeout", 32'd0, 32'd1);
      else if (expect_it) sb.push_back(v.r);
      @(posedge CLK);
      #1;
      bus.IN_VALID = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(posedge CLK);
         n++;
      end
      if (sb.size() != 0) check("drain_timeout", sb.size(), 32'd0);
      @(posedge CLK);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: sim still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vt[0]  = V(SUB, 8'h78, 8'h78, R(1, 8'h7C, 3'b100));
      vt[1]  = V(ADD, 8'h78, 8'hF8, R(1, 8'h7C, 3'b100));
      vt[2]  = V(DIV, 8'hB8, 8'h00, R(1, 8'hF8, 3'b010));
      vt[3]  = V(DIV, 8'h00, 8'h00, R(1, 8'h7C, 3'b100));
      vt[4]  = V(MUL, 8'h7A, 8'h00, R(1, 8'h7C, 3'b001));
      vt[5]  = V(MUL, 8'h38, 8'h40, R(0, 8'h00, 3'b000));
      vt[6]  = V(ADD, 8'h38, 8'h40, R(0, 8'h00, 3'b000));
      vt[7]  = V(SUB, 8'h38, 8'h78, R(1, 8'hF8, 3'b000));
      vt[8]  = V(SUB, 8'h38, 8'hF8, R(1, 8'h78, 3'b000));
      vt[9]  = V(ADD, 8'hFF, 8'h78, R(1, 8'h7C, 3'b001));
      vt[10] = V(MUL, 8'h00, 8'hF8, R(1, 8'h7C, 3'b100));
      vt[11] = V(MUL, 8'hB8, 8'h78, R(1, 8'hF8, 3'b000));
      vt[12] = V(DIV, 8'h78, 8'h78, R(1, 8'h7C, 3'b100));
      vt[13] = V(DIV, 8'h78, 8'h00, R(1, 8'h78, 3'b000));
      vt[14] = V(DIV, 8'h01, 8'h00, R(1, 8'h78, 3'b010));
      vt[15] = V(DIV, 8'h38, 8'h78, R(1, 8'h00, 3'b000));
      vt[16] = V(DIV, 8'hB8, 8'h78, R(1, 8'h80, 3'b000));
      vt[17] = V(DIV, 8'h00, 8'h38, R(0, 8'h00, 3'b000));
      vt[18] = V(DIV, 8'h00, 8'hF8, R(1, 8'h80, 3'b000));
      vt[19] = V(SUB, 8'hF8, 8'hF8, R(1, 8'h7C, 3'b100));
      vt[20] = V(ADD, 8'h80, 8'h00, R(0, 8'h00, 3'b000));

      bus.FP_OPERATION = 2'b00;
      bus.OP_A         = '0;
      bus.OP_B         = '0;
      bus.IN_VALID     = 1'b0;
      bus.OUT_READY    = 1'b1;
      bus.STICKY_CLR   = 1'b0;

      repeat (3) @(posedge CLK);
      #1;
      RST = 1'b0;
      @(negedge CLK);
      check("rst_out_valid", bus.OUT_VALID, 32'd0);
      check("rst_in_ready", bus.IN_READY, 32'd1);
      check("rst_outputs", 32'(cur), 32'd0);
      check("rst_sticky", bus.STICKY_FLAGS, 32'd0);
      @(posedge CLK);
      #1;

      // first-beat latency: visible after the second edge following accept
      send(V(ADD, 8'h78, 8'h38, R(1, 8'h78, 3'b000)), 1'b1);
      @(negedge CLK);
      check("latency_s1", bus.OUT_VALID, 32'd0);
      @(negedge CLK);
      check("latency_s2", bus.OUT_VALID, 32'd1);
      @(posedge CLK);
      #1;

      for (int i = 0; i < 21; i++) send(vt[i], 1'b1);
      drain();

      fork
         begin
            for (int i = 0; i < 6; i++) send(vt[i], 1'b1);
         end
         begin
            repeat (3) @(posedge CLK);
            #1;
            bus.OUT_READY = 1'b0;
            repeat (3) @(negedge CLK);
            check("stall_in_ready", bus.IN_READY, 32'd0);
            @(posedge CLK);
            #1;
            bus.OUT_READY = 1'b1;
         end
      join
      drain();

      bus.OUT_READY = 1'b0;
      send(vt[0], 1'b0);
      send(vt[2], 1'b0);
      RST = 1'b1;
      @(posedge CLK);
      #1;
      RST = 1'b0;
      bus.OUT_READY = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         check("flush_no_valid", bus.OUT_VALID, 32'd0);
      end
      check("flush_outputs", 32'(cur), 32'd0);
      check("flush_in_ready", bus.IN_READY, 32'd1);
      @(posedge CLK);
      #1;

`ifdef FPU_EXC_STICKY_EN
      bus.STICKY_CLR = 1'b1;
      @(posedge CLK);
      #1;
      bus.STICKY_CLR = 1'b0;
      @(negedge CLK);
      check("sticky_clear", bus.STICKY_FLAGS, 32'd0);
      @(posedge CLK);
      #1;
      send(V(DIV, 8'h00, 8'h00, R(1, 8'h7C, 3'b100)), 1'b1);
      send(V(DIV, 8'h38, 8'h00, R(1, 8'h78, 3'b010)), 1'b1);
      drain();
      @(negedge CLK);
      check("sticky_accum", bus.STICKY_FLAGS, 32'b110);
      @(posedge CLK);
      #1;
      bus.OUT_READY = 1'b0;
      send(vt[4], 1'b1);
      begin
         int n = 0;
         while (!bus.OUT_VALID && n < 20) begin
            @(posedge CLK);
            #1;
            n++;
         end
         if (!bus.OUT_VALID) check("sticky_wait_timeout", 32'd0, 32'd1);
      end
      bus.OUT_READY  = 1'b1;
      bus.STICKY_CLR = 1'b1;
      @(posedge CLK);
      #1;
      bus.STICKY_CLR = 1'b0;
      @(negedge CLK);
      check("sticky_clr_keep", bus.STICKY_FLAGS, 32'b001);
      @(posedge CLK);
      #1;
`else
      send(vt[3], 1'b1);
      drain();
      @(negedge CLK);
      check("sticky_tied", bus.STICKY_FLAGS, 32'd0);
      @(posedge CLK);
      #1;
`endif

      drain();
      check("sb_empty", sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/fpu_exception_pipe.md
Name: fpu_exception_pipe

Overview:
Parametrised, pipelined special-case detector for the small-format FPU. It classifies both operands (zero, finite, infinity, NaN) for add, sub, mul and div. It then decides whether the operation bypasses the arithmetic datapath, and if so produces the IEEE-style special result and exception flags. It sits in parallel with the arithmetic core; the result mux selects EXC_RESULT when OUT_IS_EXCEPTION=1. Valid/ready handshakes on both sides give backpressure compatibility with the core pipeline.

Parameters:
EXP_W, 4, exponent field width (>=2)
MAN_W, 3, mantissa field width (>=1); operand width W = 1+EXP_W+MAN_W (default 8)

Ports:
CLK  input  1  clock, rising edge
RST  input  1  reset, asynchronous, active-high
FP_OPERATION  input  2  00 add, 01 sub, 10 mul, 11 div
OP_A  input  W  operand A {sign, exp, man}
OP_B  input  W  operand B
IN_VALID  input  1  input beat valid
IN_READY  output  1  block accepts beat this cycle
OUT_VALID  output  1  result beat valid
OUT_READY  input  1  downstream accepts result
OUT_IS_EXCEPTION  output  1  result is special, bypass core
EXC_RESULT  output  W  special result (0 when OUT_IS_EXCEPTION=0)
EXC_FLAGS  output  3  {INVALID, DIV_BY_ZERO, NAN_IN}
STICKY_FLAGS  output  3  accumulated flags (optional feature)
STICKY_CLR  input  1  clear sticky flags (optional feature)

Behaviour:
- Encodings: exp all-ones with man=0 is inf; exp all-ones with man!=0 is NaN; exp=0 with man=0 is zero; everything else is finite (subnormals are finite nonzero). Canonical NaN QNAN = {0, all-ones exp, 1 followed by zeros}.
- Pipeline, 2 stages:
  - S1 registers the operation, signs and per-operand class. For sub, B's effective sign is inverted.
  - S2 registers the result, flags and exception bit.
  - Latency is 2 cycles from accept to OUT_VALID with no stall.
- Handshake:
  - A beat is accepted when IN_VALID&&IN_READY.
  - S2 advances when !s2_valid||OUT_READY.
  - S1 advances when !s1_valid||S2 advances.
  - IN_READY = S1 advances.
  - Full throughput of 1 beat/cycle.
  - OUT_* are held stable while OUT_VALID&&!OUT_READY.
  - A beat is never dropped or duplicated.
- Add/sub rules, in priority order:
  - Any NaN input: QNAN, NAN_IN=1.
  - inf plus inf with opposite effective signs: QNAN, INVALID=1.
  - Any inf: that inf, with the effective sign.
  - Otherwise: not an exception.
- Mul rules, in priority order:
  - Any NaN input: QNAN, NAN_IN.
  - zero*inf: QNAN, INVALID.
  - Any inf: inf with sign sA^sB.
  - Otherwise: not an exception.
- Div rules, in priority order:
  - Any NaN input: QNAN, NAN_IN.
  - 0/0 or inf/inf: QNAN, INVALID.
  - finite-nonzero/0: inf with sign sA^sB, DIV_BY_ZERO.
  - inf/x: inf with sign sA^sB.
  - x/inf: zero with sign sA^sB.
  - 0/x: not an exception; the core handles it.
- OUT_IS_EXCEPTION=1 exactly when one of the above special cases is taken. Flags are 0 otherwise.
- Reset values: s1_valid=0, s2_valid=0, OUT_VALID=0, OUT_IS_EXCEPTION=0, EXC_RESULT=0, EXC_FLAGS=0, STICKY_FLAGS=0. IN_READY=1 after reset.
- Reset mid-operation: in-flight beats are discarded; no OUT_VALID pulse follows.

Optional Feature:
Macro FPU_EXC_STICKY_EN.
- Defined:
  - On each output handshake (OUT_VALID&&OUT_READY), STICKY_FLAGS |= EXC_FLAGS.
  - STICKY_CLR=1 clears STICKY_FLAGS at the next edge.
  - Clear has priority over a simultaneous OR, but the flags of that same handshake are kept: the next value is EXC_FLAGS.
- Undefined: STICKY_FLAGS is tied to 0 and STICKY_CLR is ignored.

Test Plan:
- Defaults, add, A=0x78 (+inf), B=0x38 (+1.0), OUT_READY=1 -> 2 cycles later OUT_VALID=1, OUT_IS_EXCEPTION=1, EXC_RESULT=0x78, EXC_FLAGS=000.
- Sub, A=0x78, B=0x78 -> EXC_RESULT=0x7C, EXC_FLAGS=100. Add A=0x78, B=0xF8 -> same response.
- Div, A=0xB8 (-1.0), B=0x00 -> EXC_RESULT=0xF8, EXC_FLAGS=010. Div A=0x00, B=0x00 -> 0x7C, flags 100.
- Mul, A=0x7A (NaN), B=0x00 -> 0x7C, flags 001. Mul A=0x38, B=0x40 -> OUT_IS_EXCEPTION=0, EXC_RESULT=0x00.
- Stream 6 beats with OUT_READY low for 3 cycles mid-stream:
  - IN_READY drops after both stages fill.
  - Outputs stay stable while stalled.
  - All 6 results arrive in order.
  - RST pulse with 2 beats in flight -> no OUT_VALID afterwards, all outputs 0.
- With FPU_EXC_STICKY_EN: run the 0/0 div and 1/0 div beats -> STICKY_FLAGS=110. Assert STICKY_CLR with a NaN-input beat handshaking that same cycle -> STICKY_FLAGS=001.
